// File: rtl/booth_div.sv
// ============================================================================
// Module   : booth_div
// Purpose  : Sequential radix-2 non-restoring divider, one quotient bit per
//            cycle, valid/ready on both sides. Optional two's complement
//            operands when BOOTH_DIV_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_div #(
  parameter int WORD_LEN = 8
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WORD_LEN-1:0] i_dividend,
  input  logic [WORD_LEN-1:0] i_divisor,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WORD_LEN-1:0] o_quotient,
  output logic [WORD_LEN-1:0] o_remainder,
  output logic                o_div_by_zero
);

  localparam int            C_CW   = $clog2(WORD_LEN);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WORD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [C_CW-1:0]     r_cnt;
  logic [WORD_LEN:0]   r_rem;
  logic [WORD_LEN-1:0] r_q;
  logic [WORD_LEN-1:0] r_dvs;
  logic                r_ready;
  logic                r_valid;
  logic [WORD_LEN-1:0] r_quotient;
  logic [WORD_LEN-1:0] r_remainder;
  logic                r_dbz;

  logic [WORD_LEN:0]   w_rem_sh;
  logic [WORD_LEN:0]   w_rem_nxt;
  logic [WORD_LEN-1:0] w_rem_fix;
  logic [WORD_LEN-1:0] w_dvd_mag;
  logic [WORD_LEN-1:0] w_dvs_mag;
  logic [WORD_LEN-1:0] w_q_fin;
  logic [WORD_LEN-1:0] w_r_fin;

  // Intermediate shifted remainder may exceed WORD_LEN+1 bits, but the
  // post add/subtract result always lies in [-D, D), so modular wrap is safe.
  assign w_rem_sh  = {r_rem[WORD_LEN-1:0], r_q[WORD_LEN-1]};
  assign w_rem_nxt = r_rem[WORD_LEN] ? (w_rem_sh + {1'b0, r_dvs})
                                     : (w_rem_sh - {1'b0, r_dvs});
  assign w_rem_fix = r_rem[WORD_LEN] ? (r_rem[WORD_LEN-1:0] + r_dvs)
                                     : r_rem[WORD_LEN-1:0];

`ifdef BOOTH_DIV_SIGNED_EN
  logic r_qneg;
  logic r_rneg;

  assign w_dvd_mag = i_dividend[WORD_LEN-1] ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dvs_mag = i_divisor[WORD_LEN-1]  ? (~i_divisor + 1'b1)  : i_divisor;
  assign w_q_fin   = r_qneg ? (~r_q + 1'b1) : r_q;
  assign w_r_fin   = r_rneg ? (~w_rem_fix + 1'b1) : w_rem_fix;
`else
  assign w_dvd_mag = i_dividend;
  assign w_dvs_mag = i_divisor;
  assign w_q_fin   = r_q;
  assign w_r_fin   = w_rem_fix;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_ready <= 1'b0;
            if (i_divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= i_dividend;
              r_dbz       <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_q     <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_cnt   <= '0;
              r_state <= S_CALC;
`ifdef BOOTH_DIV_SIGNED_EN
              r_qneg  <= i_dividend[WORD_LEN-1] ^ i_divisor[WORD_LEN-1];
              r_rneg  <= i_dividend[WORD_LEN-1];
`endif
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[WORD_LEN-2:0], ~w_rem_nxt[WORD_LEN]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quotient  <= w_q_fin;
          r_remainder <= w_r_fin;
          r_dbz       <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Results are already stable on entry; valid follows one edge later.
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = r_ready;
  assign o_valid       = r_valid;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

`default_nettype wire
